mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single data read/write port of the 64K x 16 unified memory between the CPU load/store
//  unit and the debug/loader master (program download, memory inspection). The instruction fetch port
//  is not arbitrated. The CPU has fixed priority. An anti-starvation counter guarantees debug progress.
//  Sits between both masters and the memory's write/read-address ports; registers read data per master.
// PARAMETERS
//  AW        16  address width (words)
//  DW        16  data width
//  MAX_WAIT  8   cycles debug may be refused before it gets priority (1..255)
// PORTS
//  clk          in   1   system clock, all state updates on posedge
//  rst_n        in   1   asynchronous active-low reset
//  cpu_req      in   1   CPU access request; held until cpu_gnt
//  cpu_we       in   1   1 = write, 0 = read
//  cpu_addr     in   AW  CPU word address
//  cpu_wdata    in   DW  CPU write data
//  cpu_gnt      out  1   combinational: CPU access performed this cycle
//  cpu_rvalid   out  1   registered: CPU read data valid (1-cycle pulse)
//  cpu_rdata    out  DW  registered CPU read data; holds until next CPU read
//  dbg_req/dbg_we/dbg_addr/dbg_wdata/dbg_gnt/dbg_rvalid/dbg_rdata   same as cpu_* for the debug master
//  dbg_lock     in   1   [ARB_LOCK_EN only] keep ownership after this grant
//  mem_write    out  1   write strobe to memory
//  mem_waddr    out  AW  memory write address
//  mem_wdata    out  DW  memory write data
//  mem_raddr    out  AW  memory read address
//  mem_rdata    in   DW  memory read data (combinational from mem_raddr)
// BEHAVIOUR
//  - At most one grant per cycle. The grant is combinational from req and state. A grant = the access completes this cycle.
//  - Winner: if starve (dbg_wait == MAX_WAIT) and dbg_req, then debug; else if cpu_req, then CPU; else if dbg_req, then debug.
//  - Granted write: mem_write=1, mem_waddr/mem_wdata = winner's; memory updates at this posedge.
//  - Granted read: mem_raddr = winner addr; winner rdata <= mem_rdata at posedge; winner rvalid=1 next cycle only.
//  - No grant or granted read: mem_write=0. Idle mem_* address/data outputs = 0.
//  - dbg_wait (8b): +1 each cycle dbg_req && !dbg_gnt, saturating at MAX_WAIT. Cleared on dbg_gnt or !dbg_req.
//  - Read-during-write to the same address cannot occur (single port, one grant per cycle).
//  - FSM (owner): ARB (default) and LOCK_DBG (lock feature only). Without ARB_LOCK_EN the FSM stays in ARB.
//  - Reset (async, any cycle, mid-access included): FSM=ARB, dbg_wait=0, *_rvalid=0, *_rdata=0.
//    In-flight rvalid is lost. Combinational outputs follow the inputs once rst_n=1.
//  - Requesters must hold req/we/addr/wdata stable until gnt. Dropping req before gnt cancels the request silently.
// CONFIGURATION
//  ARB_LOCK_EN defined: dbg_lock port exists. A debug grant with dbg_lock=1 moves ARB->LOCK_DBG.
//    In LOCK_DBG only debug is granted (cpu_gnt=0 even if starve/priority). The state exits to ARB
//    after a debug grant with dbg_lock=0, or when dbg_req=0. dbg_wait is held at 0 while locked.
//  ARB_LOCK_EN undefined: no dbg_lock port; pure CPU priority plus anti-starvation; no LOCK_DBG state.
// TESTING
//  1 Reset: rst_n=0 mid-read -> rvalid=0, rdata=0 both; mem_write=0; after release idle outputs=0.
//  2 CPU write 0x1234 @0x0010, then read @0x0010 -> cpu_gnt each cycle; cpu_rvalid next cycle, cpu_rdata=0x1234.
//  3 Simultaneous cpu_req+dbg_req reads -> CPU granted; debug granted only after cpu_req drops.
//  4 cpu_req held high continuously, dbg_req high, MAX_WAIT=8 -> dbg_gnt exactly on the 9th cycle;
//    cpu_gnt=0 that cycle; dbg_wait back to 0.
//  5 Debug writes 0xFFFF to 0xFFFF, then reads it back -> wraps no address; dbg_rdata=0xFFFF; CPU rdata unchanged.
//  6 [ARB_LOCK_EN] dbg grant with dbg_lock=1, then cpu_req high for 4 debug lock cycles -> cpu_gnt=0 throughout;
//    the CPU is granted the cycle after a dbg grant with dbg_lock=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared memory data port between the CPU (fixed priority) and the debug master.
// A starvation counter forces a debug grant. Optional macro ARB_LOCK_EN adds dbg_lock ownership.
module mem_port_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
`ifdef ARB_LOCK_EN
  input  logic          dbg_lock,
`endif
  output logic          mem_write,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  logic [7:0] dbg_wait;
  logic       starve;
  logic       locked;

`ifdef ARB_LOCK_EN
  typedef enum logic [0:0] {ARB, LOCK_DBG} state_t;
  state_t state;
  assign locked = (state == LOCK_DBG);
`else
  assign locked = 1'b0;
`endif

  assign starve = (dbg_wait == WAIT_MAX);

  // Lock overrides everything; starvation overrides CPU priority.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (locked)                 dbg_gnt = dbg_req;
    else if (starve && dbg_req) dbg_gnt = 1'b1;
    else if (cpu_req)           cpu_gnt = 1'b1;
    else if (dbg_req)           dbg_gnt = 1'b1;
  end

  always_comb begin
    mem_write = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_raddr = '0;
    if (cpu_gnt) begin
      if (cpu_we) begin
        mem_write = 1'b1;
        mem_waddr = cpu_addr;
        mem_wdata = cpu_wdata;
      end else begin
        mem_raddr = cpu_addr;
      end
    end else if (dbg_gnt) begin
      if (dbg_we) begin
        mem_write = 1'b1;
        mem_waddr = dbg_addr;
        mem_wdata = dbg_wdata;
      end else begin
        mem_raddr = dbg_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_wait   <= '0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
`ifdef ARB_LOCK_EN
      state      <= ARB;
`endif
    end else begin
      cpu_rvalid <= cpu_gnt && !cpu_we;
      dbg_rvalid <= dbg_gnt && !dbg_we;
      if (cpu_gnt && !cpu_we) cpu_rdata <= mem_rdata;
      if (dbg_gnt && !dbg_we) dbg_rdata <= mem_rdata;
      if (!dbg_req || dbg_gnt || locked) dbg_wait <= '0;
      else if (dbg_wait != WAIT_MAX)     dbg_wait <= dbg_wait + 8'd1;
`ifdef ARB_LOCK_EN
      case (state)
        ARB:      if (dbg_gnt && dbg_lock) state <= LOCK_DBG;
        LOCK_DBG: if (!dbg_req || (dbg_gnt && !dbg_lock)) state <= ARB;
        default:  state <= ARB;
      endcase
`endif
    end
  end

endmodule
